// File: rtl/fifo_flex_if.sv
// Stream bundle for fifo_flex: producer-side push channel, consumer-side pop channel and status.
// The slave modport is the FIFO's view; master is the surrounding pipeline's view.
interface fifo_flex_if #(
    parameter int ElemWidth = 8,
    parameter int Depth     = 6
);
    localparam int CntW = $clog2(Depth + 1);

    logic [ElemWidth-1:0] elem_in_i;
    logic                 elem_in_valid_i;
    logic                 elem_in_ready_o;
    logic [ElemWidth-1:0] elem_out_o;
    logic                 elem_out_valid_o;
    logic                 elem_out_ready_i;
    logic [CntW-1:0]      count_o;
    logic                 almost_full_o;
    logic                 almost_empty_o;

    modport slave (
        input  elem_in_i, elem_in_valid_i, elem_out_ready_i,
        output elem_in_ready_o, elem_out_o, elem_out_valid_o,
        output count_o, almost_full_o, almost_empty_o
    );

    modport master (
        output elem_in_i, elem_in_valid_i, elem_out_ready_i,
        input  elem_in_ready_o, elem_out_o, elem_out_valid_o,
        input  count_o, almost_full_o, almost_empty_o
    );
endinterface

// File: rtl/fifo_flex.sv
// Elastic valid/ready FIFO with arbitrary depth, occupancy flags, synchronous flush and an
// optional fall-through path that forwards input straight to output when empty.
module fifo_flex #(
    parameter int ElemWidth     = 8,
    parameter int Depth         = 6,
    parameter int AlmostFullTh  = 5,
    parameter int AlmostEmptyTh = 1,
    parameter bit FallThrough   = 1'b1
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        flush_i,
    fifo_flex_if.slave  stream
);
    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 2) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    if (Depth < 2) begin : g_bad_depth
        $error("fifo_flex: Depth must be >= 2");
    end
    if ((AlmostFullTh < 1) || (AlmostFullTh > Depth)) begin : g_bad_af
        $error("fifo_flex: AlmostFullTh out of range 1..Depth");
    end
    if ((AlmostEmptyTh < 0) || (AlmostEmptyTh > Depth - 1)) begin : g_bad_ae
        $error("fifo_flex: AlmostEmptyTh out of range 0..Depth-1");
    end

    // Explicit wrap at Depth-1 keeps non-power-of-two depths correct.
    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
        if (ptr == LastPtr) begin
            return {PtrW{1'b0}};
        end else begin
            return ptr + PtrW'(1);
        end
    endfunction

    logic [ElemWidth-1:0] mem_r [Depth];
    logic [PtrW-1:0]      wr_ptr_r;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [CntW-1:0]      count_r;

    logic                 empty_s;
    logic                 in_ready_s;
    logic                 out_valid_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 bypass_s;
    logic                 wr_en_s;
    logic                 rd_en_s;
    logic [ElemWidth-1:0] elem_out_s;
    logic [CntW-1:0]      count_nxt_s;

    // Handshake decode, bypass detection, head selection and next occupancy.
    always_comb begin
        empty_s     = (count_r == {CntW{1'b0}});
        in_ready_s  = ~srst_i & ~flush_i & ((count_r < DepthCnt) | stream.elem_out_ready_i);
        out_valid_s = ~srst_i & ~flush_i & (~empty_s | (FallThrough & stream.elem_in_valid_i));
        push_s      = stream.elem_in_valid_i & in_ready_s;
        pop_s       = out_valid_s & stream.elem_out_ready_i;
        // An empty fall-through FIFO pops only the element it accepts in the same cycle.
        bypass_s    = FallThrough & empty_s & pop_s;
        wr_en_s     = push_s & ~bypass_s;
        rd_en_s     = pop_s & ~bypass_s;

        if (FallThrough & empty_s) begin
            elem_out_s = stream.elem_in_i;
        end else begin
            elem_out_s = mem_r[rd_ptr_r];
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CntW'(1);
            2'b01:   count_nxt_s = count_r - CntW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; reset and flush clear them identically.
    always_ff @(posedge clk_i) begin
        if (srst_i | flush_i) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage array; a full push+pop overwrites the slot being read out this same cycle.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= stream.elem_in_i;
        end
    end

    assign stream.elem_in_ready_o  = in_ready_s;
    assign stream.elem_out_valid_o = out_valid_s;
    assign stream.elem_out_o       = elem_out_s;
    assign stream.count_o          = count_r;
    assign stream.almost_full_o    = (count_r >= CntW'(AlmostFullTh));
    assign stream.almost_empty_o   = (count_r <= CntW'(AlmostEmptyTh));
endmodule

// File: tb/tb_fifo_flex.sv
// Randomised scoreboard bench for fifo_flex: a queue model predicts handshakes and flags,
// a separate monitor checks every popped element against the expected stream order.
module tb_fifo_flex;
    localparam int W  = 8;
    localparam int D  = 6;
    localparam int AF = 5;
    localparam int AE = 1;

    logic clk = 1'b0;
    logic srst;
    logic flush;
    logic flush0;

    always #5 clk = ~clk;

    fifo_flex_if #(.ElemWidth(W), .Depth(D)) ifm ();
    fifo_flex_if #(.ElemWidth(W), .Depth(D)) ift0 ();

    fifo_flex #(.ElemWidth(W), .Depth(D), .AlmostFullTh(AF), .AlmostEmptyTh(AE),
                .FallThrough(1'b1)) u_dut (
        .clk_i(clk), .srst_i(srst), .flush_i(flush), .stream(ifm.slave));

    fifo_flex #(.ElemWidth(W), .Depth(D), .AlmostFullTh(AF), .AlmostEmptyTh(AE),
                .FallThrough(1'b0)) u_dut_ft0 (
        .clk_i(clk), .srst_i(srst), .flush_i(flush0), .stream(ift0.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] mq[$];
    logic [W-1:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every element leaving the DUT must be the oldest expected one.
    always @(negedge clk) begin
        if (ifm.elem_out_valid_o === 1'b1 && ifm.elem_out_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got %0h expected no element", ifm.elem_out_o);
            end else begin
                chk("sb_data", {24'h0, ifm.elem_out_o}, {24'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic rdy,
                        input logic fl, input logic rs);
        int n;
        logic p_ir, p_ov, push, pop;
        logic [W-1:0] p_dat;
        srst = rs;
        flush = fl;
        ifm.elem_in_valid_i  = v;
        ifm.elem_in_i        = d;
        ifm.elem_out_ready_i = rdy;
        n     = mq.size();
        p_ir  = !rs && !fl && ((n < D) || rdy);
        p_ov  = !rs && !fl && ((n != 0) || v);
        push  = v && p_ir;
        pop   = p_ov && rdy;
        p_dat = (n != 0) ? mq[0] : d;
        if (push) sb_q.push_back(d);
        @(negedge clk);
        chk("in_ready", {31'h0, ifm.elem_in_ready_o}, {31'h0, p_ir});
        chk("out_valid", {31'h0, ifm.elem_out_valid_o}, {31'h0, p_ov});
        chk("count", 32'(ifm.count_o), 32'(n));
        chk("almost_full", {31'h0, ifm.almost_full_o}, {31'h0, (n >= AF)});
        chk("almost_empty", {31'h0, ifm.almost_empty_o}, {31'h0, (n <= AE)});
        if (p_ov) chk("head", {24'h0, ifm.elem_out_o}, {24'h0, p_dat});
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            sb_q.delete();
        end else if (!(pop && n == 0)) begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
        end
        #1;
    endtask

    task automatic rand_step(input int flush_odds);
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
             (flush_odds > 0) ? 1'($urandom_range(0, flush_odds - 1) == 0) : 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        srst = 1'b1;
        flush = 1'b0;
        flush0 = 1'b0;
        ifm.elem_in_valid_i = 1'b0; ifm.elem_in_i = 8'h00; ifm.elem_out_ready_i = 1'b0;
        ift0.elem_in_valid_i = 1'b0; ift0.elem_in_i = 8'h00; ift0.elem_out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of traffic, then the first post-reset element must come out.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill to Depth, attempt an extra push, then drain.
        for (int i = 0; i < D; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < D; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fall-through bypass on the main instance.
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Registered-path instance: element visible only one cycle after the push.
        ift0.elem_in_valid_i = 1'b1; ift0.elem_in_i = 8'hA5; ift0.elem_out_ready_i = 1'b1;
        @(negedge clk);
        chk("ft0_valid_first", {31'h0, ift0.elem_out_valid_o}, 32'h0);
        chk("ft0_ready_first", {31'h0, ift0.elem_in_ready_o}, 32'h1);
        @(posedge clk);
        #1;
        ift0.elem_in_valid_i = 1'b0;
        @(negedge clk);
        chk("ft0_valid_next", {31'h0, ift0.elem_out_valid_o}, 32'h1);
        chk("ft0_data_next", {24'h0, ift0.elem_out_o}, 32'hA5);
        chk("ft0_count_next", 32'(ift0.count_o), 32'h1);
        @(posedge clk);
        #1;
        ift0.elem_out_ready_i = 1'b0;
        @(negedge clk);
        chk("ft0_count_drained", 32'(ift0.count_o), 32'h0);
        chk("ft0_valid_drained", {31'h0, ift0.elem_out_valid_o}, 32'h0);
        @(posedge clk);
        #1;

        // Random traffic crossing the pointer wrap.
        for (int i = 0; i < 20; i++) rand_step(0);
        for (int i = 0; i < D; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with four stored, then long random run with occasional flushes.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) rand_step(40);

        for (int i = 0; i <= D; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
